// File: rtl/psi_seq_merge.sv
// psi_seq_merge: running intersection of N strictly ascending party sets,
// merged one party at a time against an accumulator with a two-pointer walk.
module psi_seq_merge #(
    parameter int W = 4,
    parameter int K = 4,
    parameter int N = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W*K-1:0]         in_set,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W*K-1:0]         o,
    output logic [$clog2(K+1)-1:0] o_count,
    output logic                   busy,
    output logic [1:0]             dbg_state_o,
    output logic [$clog2(N+1)-1:0] dbg_pcnt_o,
    output logic [$clog2(K+1)-1:0] dbg_acnt_o,
    output logic [W*K-1:0]         dbg_a_o
);
    // Handshakes: a party set transfers on a rising edge with in_valid && in_ready;
    // the result transfers on a rising edge with out_valid && out_ready, and
    // o/o_count stay stable while out_valid is high and out_ready is low.

    localparam int CW = $clog2(K+1);
    localparam int PW = $clog2(N+1);
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] K_C = CW'(K);
    localparam logic [PW-1:0] N_C = PW'(N);

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        MERGE  = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  a_q [K];
    logic [W-1:0]  a_d [K];
    logic [W-1:0]  s_q [K];
    logic [W-1:0]  s_d [K];
    logic [W-1:0]  b_q [K];
    logic [W-1:0]  b_d [K];
    logic [CW-1:0] acnt_q, acnt_d;
    logic [CW-1:0] ncnt_q, ncnt_d;
    logic [CW-1:0] i_q, i_d;
    logic [CW-1:0] j_q, j_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [W-1:0]  a_el;
    logic [W-1:0]  b_el;
    logic [W*K-1:0] a_flat;

    always_comb begin
        state_d = state_q;
        acnt_d  = acnt_q;
        ncnt_d  = ncnt_q;
        i_d     = i_q;
        j_d     = j_q;
        pcnt_d  = pcnt_q;
        for (int k = 0; k < K; k++) begin
            a_d[k] = a_q[k];
            s_d[k] = s_q[k];
            b_d[k] = b_q[k];
        end
        // Pointer bounds are checked before these elements are used.
        a_el = a_q[i_q[IW-1:0]];
        b_el = b_q[j_q[IW-1:0]];

        case (state_q)
            ACCEPT: begin
                if (in_valid) begin
                    for (int k = 0; k < K; k++) b_d[k] = in_set[W*k +: W];
                    if (pcnt_q == '0) begin
                        for (int k = 0; k < K; k++) a_d[k] = in_set[W*k +: W];
                        acnt_d  = K_C;
                        pcnt_d  = PW'(1);
                        state_d = (N == 1) ? DONE : ACCEPT;
                    end else begin
                        i_d     = '0;
                        j_d     = '0;
                        ncnt_d  = '0;
                        state_d = MERGE;
                    end
                end
            end
            MERGE: begin
                if ((i_q < acnt_q) && (j_q < K_C)) begin
                    if (a_el == b_el) begin
                        s_d[ncnt_q[IW-1:0]] = a_el;
                        ncnt_d = ncnt_q + CW'(1);
                        i_d    = i_q + CW'(1);
                        j_d    = j_q + CW'(1);
                    end else if (a_el < b_el) begin
                        i_d = i_q + CW'(1);
                    end else begin
                        j_d = j_q + CW'(1);
                    end
                end else begin
                    // Staging slots past ncnt may hold stale matches from earlier parties.
                    for (int k = 0; k < K; k++) a_d[k] = (CW'(k) < ncnt_q) ? s_q[k] : '0;
                    acnt_d  = ncnt_q;
                    pcnt_d  = pcnt_q + PW'(1);
                    state_d = ((pcnt_q + PW'(1)) == N_C) ? DONE : ACCEPT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    for (int k = 0; k < K; k++) a_d[k] = '0;
                    acnt_d  = '0;
                    pcnt_d  = '0;
                    state_d = ACCEPT;
                end
            end
            default: state_d = ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCEPT;
            acnt_q  <= '0;
            ncnt_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
            pcnt_q  <= '0;
            for (int k = 0; k < K; k++) begin
                a_q[k] <= '0;
                s_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            acnt_q  <= acnt_d;
            ncnt_q  <= ncnt_d;
            i_q     <= i_d;
            j_q     <= j_d;
            pcnt_q  <= pcnt_d;
            for (int k = 0; k < K; k++) begin
                a_q[k] <= a_d[k];
                s_q[k] <= s_d[k];
                b_q[k] <= b_d[k];
            end
        end
    end

    always_comb begin
        a_flat = '0;
        for (int k = 0; k < K; k++) a_flat[W*k +: W] = a_q[k];
    end

    assign in_ready    = (state_q == ACCEPT);
    assign busy        = (state_q == MERGE);
    assign out_valid   = (state_q == DONE);
    assign o           = out_valid ? a_flat : '0;
    assign o_count     = out_valid ? acnt_q : '0;
    assign dbg_state_o = state_q;
    assign dbg_pcnt_o  = pcnt_q;
    assign dbg_acnt_o  = acnt_q;
    assign dbg_a_o     = a_flat;

endmodule

// File: tb/tb_psi_seq_merge.sv
// Bench for psi_seq_merge: set-mask reference model checked every cycle on
// three instances (N=8, N=2, N=1), plus directed literal cases and random runs.
module tb_psi_seq_merge;

    localparam logic [1:0] P_ACC  = 2'd0;
    localparam logic [1:0] P_MRG  = 2'd1;
    localparam logic [1:0] P_DONE = 2'd2;

    typedef struct packed {
        logic [1:0]  ph;
        logic [7:0]  cnt;
        logic [15:0] acc;
        logic [15:0] pend;
        logic [7:0]  left;
    } mdl_t;

    int checks = 0;
    int failures = 0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    // ---------------- N=8 instance ----------------
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
    logic [15:0] in_set = '0, o, dbg_a;
    logic [2:0]  o_count, dbg_acnt;
    logic [3:0]  dbg_pcnt;
    logic [1:0]  dbg_state;

    psi_seq_merge #(.W(4), .K(4), .N(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_set(in_set), .out_valid(out_valid), .out_ready(out_ready),
        .o(o), .o_count(o_count), .busy(busy), .dbg_state_o(dbg_state),
        .dbg_pcnt_o(dbg_pcnt), .dbg_acnt_o(dbg_acnt), .dbg_a_o(dbg_a)
    );

    // ---------------- N=2 instance ----------------
    logic        in_valid_2 = 1'b0, in_ready_2, out_valid_2, out_ready_2 = 1'b0, busy_2;
    logic [15:0] in_set_2 = '0, o_2, dbg_a_2;
    logic [2:0]  o_count_2, dbg_acnt_2;
    logic [1:0]  dbg_pcnt_2;
    logic [1:0]  dbg_state_2;

    psi_seq_merge #(.W(4), .K(4), .N(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_2), .in_ready(in_ready_2),
        .in_set(in_set_2), .out_valid(out_valid_2), .out_ready(out_ready_2),
        .o(o_2), .o_count(o_count_2), .busy(busy_2), .dbg_state_o(dbg_state_2),
        .dbg_pcnt_o(dbg_pcnt_2), .dbg_acnt_o(dbg_acnt_2), .dbg_a_o(dbg_a_2)
    );

    // ---------------- N=1 instance ----------------
    logic        in_valid_1 = 1'b0, in_ready_1, out_valid_1, out_ready_1 = 1'b0, busy_1;
    logic [15:0] in_set_1 = '0, o_1, dbg_a_1;
    logic [2:0]  o_count_1, dbg_acnt_1;
    logic [0:0]  dbg_pcnt_1;
    logic [1:0]  dbg_state_1;

    psi_seq_merge #(.W(4), .K(4), .N(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_1), .in_ready(in_ready_1),
        .in_set(in_set_1), .out_valid(out_valid_1), .out_ready(out_ready_1),
        .o(o_1), .o_count(o_count_1), .busy(busy_1), .dbg_state_o(dbg_state_1),
        .dbg_pcnt_o(dbg_pcnt_1), .dbg_acnt_o(dbg_acnt_1), .dbg_a_o(dbg_a_1)
    );

    // ---------------- set helpers (sets as 16-bit membership masks) ----------------
    function automatic logic [15:0] to_mask(input logic [15:0] s);
        logic [15:0] m;
        m = '0;
        for (int e = 0; e < 4; e++) m[s[4*e +: 4]] = 1'b1;
        return m;
    endfunction

    function automatic logic [15:0] to_packed(input logic [15:0] m);
        logic [15:0] p;
        int s;
        p = '0;
        s = 0;
        for (int v = 0; v < 16; v++) begin
            if (m[v] && s < 4) begin
                p[4*s +: 4] = 4'(v);
                s++;
            end
        end
        return p;
    endfunction

    function automatic int popc(input logic [15:0] m);
        int c;
        c = 0;
        for (int v = 0; v < 16; v++) c += int'(m[v]);
        return c;
    endfunction

    function automatic int top(input logic [15:0] m);
        int t;
        t = -1;
        for (int v = 0; v < 16; v++) if (m[v]) t = v;
        return t;
    endfunction

    // Compare steps of an ascending two-list walk that stops when either list
    // runs out: every element up to the smaller maximum is visited, matches once.
    function automatic int steps(input logic [15:0] a, input logic [15:0] b);
        int mn;
        logic [15:0] low;
        if (a == '0) return 0;
        mn = (top(a) < top(b)) ? top(a) : top(b);
        low = '0;
        for (int v = 0; v <= mn; v++) low[v] = 1'b1;
        return popc(a & low) + popc(b & low) - popc(a & b);
    endfunction

    function automatic mdl_t model_step(input mdl_t m, input int n, input logic r,
                                        input logic v, input logic [15:0] s,
                                        input logic ordy);
        mdl_t x;
        x = m;
        if (r) begin
            x = '0;
            return x;
        end
        case (m.ph)
            P_ACC: begin
                if (v) begin
                    if (m.cnt == 0) begin
                        x.acc = to_mask(s);
                        x.cnt = 8'd1;
                        x.ph  = (n == 1) ? P_DONE : P_ACC;
                    end else begin
                        x.pend = to_mask(s);
                        x.left = 8'(steps(m.acc, x.pend) + 1);
                        x.ph   = P_MRG;
                    end
                end
            end
            P_MRG: begin
                x.left = m.left - 8'd1;
                if (x.left == 0) begin
                    x.acc = m.acc & m.pend;
                    x.cnt = m.cnt + 8'd1;
                    x.ph  = (int'(x.cnt) == n) ? P_DONE : P_ACC;
                end
            end
            P_DONE: begin
                if (ordy) begin
                    x.acc = '0;
                    x.cnt = '0;
                    x.ph  = P_ACC;
                end
            end
            default: x.ph = P_ACC;
        endcase
        return x;
    endfunction

    function automatic logic [15:0] rand_set(input int range);
        logic [15:0] m;
        m = '0;
        while (popc(m) < 4) m[$urandom_range(range, 0)] = 1'b1;
        return to_packed(m);
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
    endtask

    task automatic check_cycle(input string nm, input mdl_t m, input int n,
                               input logic ir, input logic bz, input logic ov,
                               input logic [15:0] oo, input logic [2:0] oc,
                               input logic [3:0] pc, input logic [2:0] ac,
                               input logic [15:0] aa);
        logic dn;
        dn = (m.ph == P_DONE);
        chk({nm, " in_ready"},  32'(ir), 32'(m.ph == P_ACC));
        chk({nm, " busy"},      32'(bz), 32'(m.ph == P_MRG));
        chk({nm, " out_valid"}, 32'(ov), 32'(dn));
        chk({nm, " o"},         32'(oo), dn ? 32'(to_packed(m.acc)) : 32'd0);
        chk({nm, " o_count"},   32'(oc), dn ? 32'(popc(m.acc)) : 32'd0);
        chk({nm, " pcnt"},      32'(pc), 32'(m.cnt));
        chk({nm, " pcnt_le_n"}, 32'(int'(pc) <= n), 32'd1);
        chk({nm, " acnt"},      32'(ac), 32'(popc(m.acc)));
        chk({nm, " acc"},       32'(aa), 32'(to_packed(m.acc)));
    endtask

    mdl_t m8 = '0, m2 = '0, m1 = '0;
    logic on = 1'b0;

    // Inputs change on the falling edge; models step on the rising edge and
    // outputs are compared shortly after it.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) on = 1'b1;
            if (on) begin
                m8 = model_step(m8, 8, rst, in_valid, in_set, out_ready);
                m2 = model_step(m2, 2, rst, in_valid_2, in_set_2, out_ready_2);
                m1 = model_step(m1, 1, rst, in_valid_1, in_set_1, out_ready_1);
            end
            #2;
            if (on) begin
                check_cycle("u8", m8, 8, in_ready, busy, out_valid, o, o_count,
                            dbg_pcnt, dbg_acnt, dbg_a);
                check_cycle("u2", m2, 2, in_ready_2, busy_2, out_valid_2, o_2, o_count_2,
                            {2'b00, dbg_pcnt_2}, dbg_acnt_2, dbg_a_2);
                check_cycle("u1", m1, 1, in_ready_1, busy_1, out_valid_1, o_1, o_count_1,
                            {3'b000, dbg_pcnt_1}, dbg_acnt_1, dbg_a_1);
            end
        end
    end

    // ---------------- driver tasks (N=8 instance) ----------------
    task automatic send(input logic [15:0] s, output int bc);
        int t;
        t = 0;
        bc = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_set = s;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) tmo("send");
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (busy && t < 200) begin
            bc++;
            @(negedge clk);
            t++;
        end
        if (t >= 200) tmo("send_busy");
    endtask

    task automatic drain(input int d);
        int t;
        t = 0;
        while (!out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) tmo("wait_done");
        repeat (d) @(negedge clk);
        out_ready = 1'b1;
        chk("drain_in_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        chk("drain_back_to_accept", 32'(in_ready), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] sets32 [8];
    int bc;
    int t;
    int range;

    initial begin
        sets32 = '{16'h4321, 16'h6542, 16'h7621, 16'h7652,
                   16'h5321, 16'h7652, 16'h7643, 16'h7653};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset in_ready",  32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset busy",      32'(busy), 32'd0);
        chk("reset o",         32'(o), 32'd0);
        chk("reset o_count",   32'(o_count), 32'd0);

        // N=1: result the cycle after load, held, then released.
        @(negedge clk);
        chk("n1 idle in_ready", 32'(in_ready_1), 32'd1);
        in_valid_1 = 1'b1;
        in_set_1 = 16'h9753;
        @(negedge clk);
        in_valid_1 = 1'b0;
        chk("n1 out_valid", 32'(out_valid_1), 32'd1);
        chk("n1 o_count", 32'(o_count_1), 32'd4);
        chk("n1 o", 32'(o_1), 32'h9753);
        repeat (3) begin
            @(negedge clk);
            chk("n1 hold o", 32'(o_1), 32'h9753);
            chk("n1 hold out_valid", 32'(out_valid_1), 32'd1);
        end
        out_ready_1 = 1'b1;
        chk("n1 release in_ready", 32'(in_ready_1), 32'd0);
        @(negedge clk);
        out_ready_1 = 1'b0;
        chk("n1 after in_ready", 32'(in_ready_1), 32'd1);
        chk("n1 after o", 32'(o_1), 32'd0);

        // N=2: {1,2,3,4} then {2,4,5,6}.
        @(negedge clk);
        in_valid_2 = 1'b1;
        in_set_2 = 16'h4321;
        @(negedge clk);
        chk("n2 second accept", 32'(in_ready_2), 32'd1);
        in_set_2 = 16'h6542;
        @(negedge clk);
        in_valid_2 = 1'b0;
        bc = 0;
        t = 0;
        while (busy_2 && t < 50) begin
            bc++;
            @(negedge clk);
            t++;
        end
        chk("n2 merge cycles", 32'(bc), 32'd5);
        chk("n2 out_valid", 32'(out_valid_2), 32'd1);
        chk("n2 o", 32'(o_2), 32'h0042);
        chk("n2 o_count", 32'(o_count_2), 32'd2);
        out_ready_2 = 1'b1;
        @(negedge clk);
        out_ready_2 = 1'b0;

        // N=8 fixed sequence: {2} survives six parties, empty after seven.
        for (int p = 0; p < 6; p++) send(sets32[p], bc);
        chk("seq8 acnt after 6", 32'(dbg_acnt), 32'd1);
        chk("seq8 a after 6", 32'(dbg_a), 32'h0002);
        send(sets32[6], bc);
        chk("seq8 acnt after 7", 32'(dbg_acnt), 32'd0);
        send(sets32[7], bc);
        chk("seq8 empty merge cycles", 32'(bc), 32'd1);
        chk("seq8 out_valid", 32'(out_valid), 32'd1);
        chk("seq8 o", 32'(o), 32'd0);
        chk("seq8 o_count", 32'(o_count), 32'd0);
        drain(1);

        // Empty accumulator: every later merge is a single commit cycle.
        send(16'h4321, bc);
        send(16'h8765, bc);
        chk("disjoint merge cycles", 32'(bc), 32'd5);
        send(16'hBA98, bc);
        chk("empty merge cycles p3", 32'(bc), 32'd1);
        for (int p = 3; p < 8; p++) begin
            send(rand_set(15), bc);
            chk("empty merge cycles", 32'(bc), 32'd1);
        end
        chk("empty o_count", 32'(o_count), 32'd0);
        drain(0);

        // Reset during the third merge cycle.
        send(16'h4321, bc);
        @(negedge clk);
        in_valid = 1'b1;
        in_set = 16'h6542;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst merge c1", 32'(busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("rst merge c3", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst o", 32'(o), 32'd0);
        chk("rst pcnt", 32'(dbg_pcnt), 32'd0);

        // Fresh run after reset: identical sets survive whole.
        send(16'h4321, bc);
        for (int p = 1; p < 8; p++) begin
            send(16'h4321, bc);
            chk("fresh merge cycles", 32'(bc), 32'd5);
        end
        chk("fresh o", 32'(o), 32'h4321);
        chk("fresh o_count", 32'(o_count), 32'd4);
        drain(2);

        // in_valid held high through every state.
        @(negedge clk);
        in_valid = 1'b1;
        for (int c = 0; c < 150; c++) begin
            in_set = rand_set($urandom_range(15, 3));
            out_ready = ($urandom_range(3, 0) == 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Random runs.
        for (int r = 0; r < 25; r++) begin
            range = $urandom_range(15, 3);
            for (int p = 0; p < 8; p++) begin
                repeat ($urandom_range(2, 0)) @(negedge clk);
                send(rand_set(range), bc);
            end
            drain($urandom_range(3, 0));
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
